// File: rtl/sc_stream_decoder_pkg.sv
// sc_pkg: shared state encoding, stream/result sizing and the count-to-result scaling used by the
// stochastic stream decoder and its reference model.
package sc_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LOG_LEN = 8;
    localparam int DEF_SHIFT_W = 5;
    localparam int RES_W = 2 * DEF_DATA_WIDTH;
    localparam int L = 1 << DEF_LOG_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A full-ones stream saturates rather than wrapping to zero in the fixed-point result.
    function automatic logic [RES_W-1:0] scale_and_shift(input logic [DEF_LOG_LEN:0] count,
                                                         input logic [DEF_SHIFT_W-1:0] shift);
        logic [RES_W-1:0] raw;
        raw = (count == (DEF_LOG_LEN + 1)'(L)) ? '1 : RES_W'(count) << (RES_W - DEF_LOG_LEN);
        return raw >> shift;
    endfunction
endpackage

// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if: job configuration, stream-bit and result handshakes of the decoder.
interface sc_stream_decoder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT_W = 5
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [SHIFT_W-1:0]      cfg_shift;
    logic                    bit_valid;
    logic                    bit_ready;
    logic                    bit_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WIDTH-1:0] out_data;

    modport master (
        output cfg_valid, cfg_shift, bit_valid, bit_in, out_ready,
        input  cfg_ready, bit_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_shift, bit_valid, bit_in, out_ready,
        output cfg_ready, bit_ready, out_valid, out_data
    );
endinterface

// File: rtl/sc_ones_counter.sv
// sc_ones_counter: stream-position counter plus ones accumulator with clear/enable and a flag
// marking acceptance of the final stream bit.
module sc_ones_counter #(
    parameter int LOG_LEN = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [LOG_LEN:0] count_nxt,
    output logic             last
);
    logic [LOG_LEN:0]   count_q, count_d;
    logic [LOG_LEN-1:0] pos_q, pos_d;

    always_comb begin
        count_d = clr ? '0 : en ? count_q + (LOG_LEN + 1)'(bit_in) : count_q;
        pos_d = clr ? '0 : en ? pos_q + LOG_LEN'(1) : pos_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            pos_q <= '0;
        end else begin
            count_q <= count_d;
            pos_q <= pos_d;
        end
    end

    // The top samples the next count so the final bit is included in the result.
    assign count_nxt = count_d;
    assign last = en & (&pos_q);
endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts ones in a 2^LOG_LEN-bit stochastic stream and returns the scaled,
// normalized binary result through a valid/ready output.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LOG_LEN = DEF_LOG_LEN,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input logic                clock,
    input logic                reset,
    sc_stream_decoder_if.slave io
);
    state_e                  state_q, state_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic                    bit_ready_q, bit_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [LOG_LEN:0]        count_nxt;
    logic                    last;
    logic                    cfg_fire, bit_fire, out_fire;

    assign cfg_fire = cfg_ready_q & io.cfg_valid;
    assign bit_fire = bit_ready_q & io.bit_valid;
    assign out_fire = out_valid_q & io.out_ready;

    sc_ones_counter #(.LOG_LEN(LOG_LEN)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      (cfg_fire),
        .en       (bit_fire),
        .bit_in   (io.bit_in),
        .count_nxt(count_nxt),
        .last     (last)
    );

    // Handshake outputs follow the next state, so each is registered and changes one cycle after its cause.
    always_comb begin
        state_d = cfg_fire ? ACCUM : last ? DONE : out_fire ? IDLE : state_q;
        cfg_ready_d = state_d == IDLE;
        bit_ready_d = state_d == ACCUM;
        out_valid_d = state_d == DONE;
        shift_d = cfg_fire ? io.cfg_shift : shift_q;
        out_data_d = last ? scale_and_shift(count_nxt, shift_q) : out_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cfg_ready_q <= 1'b1;
            bit_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            shift_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            cfg_ready_q <= cfg_ready_d;
            bit_ready_q <= bit_ready_d;
            out_valid_q <= out_valid_d;
            shift_q <= shift_d;
            out_data_q <= out_data_d;
        end
    end

    assign io.cfg_ready = cfg_ready_q;
    assign io.bit_ready = bit_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data = out_data_q;
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: directed jobs push hand-computed results into a scoreboard queue that a
// separate monitor drains on each output handshake.
module tb_sc_stream_decoder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    sc_stream_decoder_if #(.DATA_WIDTH(16), .SHIFT_W(5)) io ();

    sc_stream_decoder dut (
        .clock(clock),
        .reset(reset),
        .io   (io.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && io.out_valid && io.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", io.out_data, 32'hx);
            else check("out_data", io.out_data, exp_q.pop_front());
        end
    end

    task automatic job(input logic [4:0] sh, input logic [255:0] b, input bit gaps,
                       input bit illegal, input int stall, input logic [31:0] exp);
        exp_q.push_back(exp);
        if (illegal) begin
            io.bit_valid = 1'b1;
            io.bit_in = 1'b1;
            repeat (3) @(posedge clock);
            #1;
        end
        io.cfg_valid = 1'b1;
        io.cfg_shift = sh;
        @(posedge clock);
        #1;
        if (illegal) io.cfg_shift = ~sh;
        else io.cfg_valid = 1'b0;
        check("accum_bit_ready", 32'(io.bit_ready), 32'd1);
        check("accum_cfg_ready", 32'(io.cfg_ready), 32'd0);
        io.out_ready = (stall == 0);
        for (int i = 0; i < 256; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                io.bit_valid = 1'b0;
                io.bit_in = 1'b1;
                @(posedge clock);
                #1;
            end
            io.bit_valid = 1'b1;
            io.bit_in = b[i];
            if (i == 255) check("out_valid_early", 32'(io.out_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        io.bit_valid = 1'b0;
        io.cfg_valid = 1'b0;
        check("out_valid_latency", 32'(io.out_valid), 32'd1);
        check("done_bit_ready", 32'(io.bit_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            check("stall_out_valid", 32'(io.out_valid), 32'd1);
            check("stall_out_data", io.out_data, exp);
            check("stall_cfg_ready", 32'(io.cfg_ready), 32'd0);
            check("stall_bit_ready", 32'(io.bit_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        io.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("post_out_valid", 32'(io.out_valid), 32'd0);
        check("post_cfg_ready", 32'(io.cfg_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        io.cfg_valid = 1'b0;
        io.cfg_shift = '0;
        io.bit_valid = 1'b0;
        io.bit_in = 1'b0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_cfg_ready", 32'(io.cfg_ready), 32'd1);
        check("rst_bit_ready", 32'(io.bit_ready), 32'd0);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_out_data", io.out_data, 32'h0);
        reset = 1'b0;

        job(5'd0, {128{2'b01}}, 1'b0, 1'b0, 0, 32'h8000_0000);
        job(5'd4, {64{4'b0001}}, 1'b1, 1'b0, 0, 32'h0400_0000);
        job(5'd0, {256{1'b1}}, 1'b0, 1'b0, 0, 32'hFFFF_FFFF);
        job(5'd0, 256'd0, 1'b0, 1'b0, 0, 32'h0000_0000);
        job(5'd31, {{255{1'b1}}, 1'b0}, 1'b0, 1'b0, 0, 32'h0000_0001);
        job(5'd0, {256{1'b1}}, 1'b0, 1'b0, 5, 32'hFFFF_FFFF);
        job(5'd0, {{224{1'b0}}, {32{1'b1}}}, 1'b0, 1'b0, 0, 32'h2000_0000);

        io.cfg_valid = 1'b1;
        io.cfg_shift = 5'd0;
        @(posedge clock);
        #1;
        io.cfg_valid = 1'b0;
        io.bit_valid = 1'b1;
        io.bit_in = 1'b1;
        repeat (100) @(posedge clock);
        #1;
        reset = 1'b1;
        io.bit_valid = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_cfg_ready", 32'(io.cfg_ready), 32'd1);
        check("midrst_bit_ready", 32'(io.bit_ready), 32'd0);
        check("midrst_out_valid", 32'(io.out_valid), 32'd0);
        check("midrst_out_data", io.out_data, 32'h0);
        reset = 1'b0;
        job(5'd0, {256{1'b1}}, 1'b0, 1'b0, 0, 32'hFFFF_FFFF);

        job(5'd0, {{240{1'b0}}, {16{1'b1}}}, 1'b0, 1'b1, 0, 32'h1000_0000);

        repeat (3) @(posedge clock);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
